// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked, registered ALU with a flags register and an
// accumulator operand mode. Flags are {ERR,V,N,C,Z}.
// Build macro ALU_MUL_EN: when defined, opcode A runs a WIDTH-cycle
// shift-add multiplier through the EXEC state; when undefined, opcode A
// takes the illegal-op path and result_hi is tied to zero.
module alu_seq_core #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             use_acc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [4:0]       flags
);
   localparam int unsigned SW = $clog2(WIDTH);

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
      OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
      OP_ADC = 4'h8, OP_CMP = 4'h9, OP_MUL = 4'hA
   } opcode_t;

   state_t           state_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] result_q;
   logic [4:0]       flags_q;
   logic             out_valid_q;
   logic             accwr_q;

   logic [WIDTH-1:0] opa;
   logic [SW-1:0]    sh;
   logic [WIDTH:0]   add_t;
   logic [WIDTH:0]   sub_t;
   logic [WIDTH:0]   shl_t;
   logic [WIDTH:0]   shr_t;
   logic [WIDTH-1:0] res_d;
   logic [4:0]       flags_d;
   logic             c_d;
   logic             v_d;
   logic             err_d;
   logic             accwr_d;
   logic             mul_d;

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0]   result_hi_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH-1:0]   mcand_q;
   logic [SW-1:0]      cnt_q;
   logic [WIDTH:0]     psum;
   logic               mul_hi_nz;

   // One shift-add step: conditionally add the multiplicand into the high half, then shift right
   always_comb begin
      psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_d    = {psum, prod_q[WIDTH-1:1]};
      mul_hi_nz = (prod_d[2*WIDTH-1:WIDTH] != '0);
   end
`endif

   // Single-cycle ALU evaluated on the operands presented at the accept edge
   always_comb begin
      opa     = use_acc ? acc_q : a;
      sh      = b[SW-1:0];
      add_t   = {1'b0, opa} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & flags_q[1]};
      sub_t   = {1'b0, opa} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      // One extra bit on the far side of each shift catches the last bit shifted out
      shl_t   = {1'b0, opa} << sh;
      shr_t   = {opa, 1'b0} >> sh;
      res_d   = '0;
      c_d     = 1'b0;
      v_d     = 1'b0;
      err_d   = 1'b0;
      accwr_d = 1'b1;
      mul_d   = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            res_d = add_t[WIDTH-1:0];
            c_d   = add_t[WIDTH];
            v_d   = (opa[WIDTH-1] == b[WIDTH-1]) && (add_t[WIDTH-1] != opa[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            res_d = sub_t[WIDTH-1:0];
            c_d   = sub_t[WIDTH];
            v_d   = (opa[WIDTH-1] != b[WIDTH-1]) && (sub_t[WIDTH-1] != opa[WIDTH-1]);
         end
         OP_AND: res_d = opa & b;
         OP_OR:  res_d = opa | b;
         OP_XOR: res_d = opa ^ b;
         OP_NOT: res_d = ~opa;
         OP_SHL: begin
            res_d = shl_t[WIDTH-1:0];
            c_d   = shl_t[WIDTH];
         end
         OP_SHR: begin
            res_d = shr_t[WIDTH:1];
            c_d   = shr_t[0];
         end
`ifdef ALU_MUL_EN
         OP_MUL: mul_d = 1'b1;
`endif
         default: begin
            err_d   = 1'b1;
            accwr_d = 1'b0;
         end
      endcase
      flags_d = {err_d, v_d, res_d[WIDTH-1], c_d, (res_d == '0)};
      // CMP keeps the subtraction's flags but returns A and leaves acc alone
      if (op == OP_CMP) begin
         res_d   = opa;
         accwr_d = 1'b0;
      end
   end

   // Control FSM with registered result, flags, valid and accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         accwr_q     <= 1'b0;
`ifdef ALU_MUL_EN
         result_hi_q <= '0;
         prod_q      <= '0;
         mcand_q     <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  accwr_q <= accwr_d;
                  if (mul_d) begin
`ifdef ALU_MUL_EN
                     prod_q  <= {{WIDTH{1'b0}}, b};
                     mcand_q <= opa;
                     cnt_q   <= '0;
                     state_q <= S_EXEC;
`endif
                  end else begin
                     result_q    <= res_d;
                     flags_q     <= flags_d;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
`ifdef ALU_MUL_EN
                     result_hi_q <= '0;
`endif
                  end
               end
            end
`ifdef ALU_MUL_EN
            S_EXEC: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == SW'(WIDTH - 1)) begin
                  result_q    <= prod_d[WIDTH-1:0];
                  result_hi_q <= prod_d[2*WIDTH-1:WIDTH];
                  flags_q     <= {1'b0, mul_hi_nz, prod_d[WIDTH-1], mul_hi_nz, (prod_d == '0)};
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
                  if (accwr_q) begin
                     acc_q <= result_q;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
`ifdef ALU_MUL_EN
   assign result_hi = result_hi_q;
`else
   assign result_hi = '0;
`endif

endmodule
